// File: rtl/uart_tx_frm.sv
// UART framing transmitter: splits one payload word into NCHAR characters (LSB first),
// each sent as start, data, optional parity, stop bits, with optional idle gap between characters.
module uart_tx_frm #(
  parameter int DATA_W   = 18,
  parameter int CHAR_W   = 8,
  parameter int NUM_STOP = 2,
  parameter int PARITY   = 0,
  parameter int GAP_BITS = 0,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_done,
  output logic              tx_busy,
  output logic              uart_sout
);

  localparam int NCHAR  = (DATA_W + CHAR_W - 1) / CHAR_W;
  localparam int SR_W   = NCHAR * CHAR_W;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(CHAR_W);
  localparam int SG_W   = 4;
  localparam int CHR_W  = (NCHAR > 1) ? $clog2(NCHAR) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SG_W-1:0]   sg_q, sg_d;
  logic [CHR_W-1:0]  chr_q, chr_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              done_c;
  logic              bit_end;
  logic [CHAR_W-1:0] cur_chr;
  logic              par_bit;

  assign bit_end = (baud_q == BAUD_W'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sg_d    = sg_q;
    chr_d   = chr_q;
    shift_d = shift_q;
    done_c  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          sg_d    = '0;
          chr_d   = '0;
          shift_d = '0;
          shift_d[DATA_W-1:0] = tx_data;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(CHAR_W - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            sg_d    = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          sg_d    = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (sg_q == SG_W'(NUM_STOP - 1)) begin
            sg_d = '0;
            if (chr_q == CHR_W'(NCHAR - 1)) begin
              state_d = S_IDLE;
              done_c  = 1'b1;
            end else begin
              chr_d   = chr_q + CHR_W'(1);
              shift_d = shift_q >> CHAR_W;
              state_d = (GAP_BITS > 0) ? S_GAP : S_START;
            end
          end else begin
            sg_d = sg_q + SG_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (sg_q == SG_W'(GAP_BITS - 1)) begin
            state_d = S_START;
            sg_d    = '0;
          end else begin
            sg_d = sg_q + SG_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so the registered output lines up with it.
  always_comb begin
    cur_chr = shift_d[CHAR_W-1:0];
    par_bit = (^cur_chr) ^ (PARITY == 2);
    case (state_d)
      S_START:  sout_d = 1'b0;
      S_DATA:   sout_d = cur_chr[bit_d];
      S_PARITY: sout_d = par_bit;
      default:  sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sg_q    <= '0;
      chr_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sg_q    <= sg_d;
      chr_q   <= chr_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
    end
  end

  assign tx_ready  = (state_q == S_IDLE);
  assign tx_busy   = ~tx_ready;
  assign tx_done   = done_c;
  assign uart_sout = sout_q;

endmodule

// File: tb/tb_uart_tx_frm.sv
// Bench for uart_tx_frm: four parameter sets driven with directed and random payloads,
// each frame compared cycle by cycle against a bit-list model of the serial line.
module tb_uart_tx_frm;

  logic        clk = 1'b0;
  logic        rst_x;
  logic [3:0]  valid_r;
  logic [17:0] data_r [4];
  logic [3:0]  ready_w, busy_w, done_w, sout_w;

  int checks = 0;
  int errors = 0;

  int dw_c  [4] = '{18, 12, 8, 8};
  int cw_c  [4] = '{8, 7, 8, 8};
  int ns_c  [4] = '{2, 1, 2, 2};
  int par_c [4] = '{0, 0, 1, 2};
  int gap_c [4] = '{0, 3, 0, 0};
  int bd_c  [4] = '{4, 5, 4, 4};

  bit exp_q [$];

  always #5 clk = ~clk;

  uart_tx_frm u_dut0 (
    .clk(clk), .rst_x(rst_x), .tx_valid(valid_r[0]), .tx_ready(ready_w[0]),
    .tx_data(data_r[0]), .tx_done(done_w[0]), .tx_busy(busy_w[0]), .uart_sout(sout_w[0])
  );

  uart_tx_frm #(.DATA_W(12), .CHAR_W(7), .NUM_STOP(1), .PARITY(0), .GAP_BITS(3), .BAUD_DIV(5)) u_dut1 (
    .clk(clk), .rst_x(rst_x), .tx_valid(valid_r[1]), .tx_ready(ready_w[1]),
    .tx_data(data_r[1][11:0]), .tx_done(done_w[1]), .tx_busy(busy_w[1]), .uart_sout(sout_w[1])
  );

  uart_tx_frm #(.DATA_W(8), .CHAR_W(8), .NUM_STOP(2), .PARITY(1), .GAP_BITS(0), .BAUD_DIV(4)) u_dut2 (
    .clk(clk), .rst_x(rst_x), .tx_valid(valid_r[2]), .tx_ready(ready_w[2]),
    .tx_data(data_r[2][7:0]), .tx_done(done_w[2]), .tx_busy(busy_w[2]), .uart_sout(sout_w[2])
  );

  uart_tx_frm #(.DATA_W(8), .CHAR_W(8), .NUM_STOP(2), .PARITY(2), .GAP_BITS(0), .BAUD_DIV(4)) u_dut3 (
    .clk(clk), .rst_x(rst_x), .tx_valid(valid_r[3]), .tx_ready(ready_w[3]),
    .tx_data(data_r[3][7:0]), .tx_done(done_w[3]), .tx_busy(busy_w[3]), .uart_sout(sout_w[3])
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Expected line level for every cycle of a frame, from the framing rules.
  function automatic void build(input int c, input logic [17:0] d);
    int  nch;
    int  idx;
    bit  b;
    bit  p;
    exp_q.delete();
    nch = (dw_c[c] + cw_c[c] - 1) / cw_c[c];
    for (int ch = 0; ch < nch; ch++) begin
      p = 1'b0;
      repeat (bd_c[c]) exp_q.push_back(1'b0);
      for (int i = 0; i < cw_c[c]; i++) begin
        idx = ch * cw_c[c] + i;
        b = (idx < dw_c[c]) ? d[idx] : 1'b0;
        p ^= b;
        repeat (bd_c[c]) exp_q.push_back(b);
      end
      if (par_c[c] != 0) begin
        b = (par_c[c] == 1) ? p : ~p;
        repeat (bd_c[c]) exp_q.push_back(b);
      end
      repeat (ns_c[c] * bd_c[c]) exp_q.push_back(1'b1);
      if (ch < nch - 1) begin
        repeat (gap_c[c] * bd_c[c]) exp_q.push_back(1'b1);
      end
    end
  endfunction

  // Entered at the falling edge of the accept cycle; returns at the falling edge of T+L+1.
  task automatic run_frame(input int c, input logic [17:0] d, input bit keep, input logic [17:0] nd);
    int len;
    build(c, d);
    len = exp_q.size();
    valid_r[c] = 1'b1;
    data_r[c]  = d;
    chk("ready_at_accept", c, ready_w[c], 1);
    @(posedge clk);
    #1;
    valid_r[c] = keep;
    data_r[c]  = keep ? nd : 18'($urandom);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("sout", c, sout_w[c], exp_q[k-1]);
      chk("done", c, done_w[c], (k == len));
      chk("busy", c, busy_w[c], 1);
      chk("ready_busy", c, ready_w[c], 0);
    end
    @(negedge clk);
    chk("ready_end", c, ready_w[c], 1);
    chk("busy_end", c, busy_w[c], 0);
    chk("sout_end", c, sout_w[c], 1);
    chk("done_end", c, done_w[c], 0);
  endtask

  function automatic logic [17:0] rnd(input int c);
    logic [17:0] msk;
    msk = 18'((1 << dw_c[c]) - 1);
    return 18'($urandom) & msk;
  endfunction

  initial begin
    logic [17:0] d1, d2;
    rst_x   = 1'b0;
    valid_r = '0;
    for (int c = 0; c < 4; c++) data_r[c] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk("rst_sout", c, sout_w[c], 1);
      chk("rst_ready", c, ready_w[c], 1);
    end
    rst_x = 1'b1;

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        chk("idle_sout", c, sout_w[c], 1);
        chk("idle_ready", c, ready_w[c], 1);
        chk("idle_busy", c, busy_w[c], 0);
        chk("idle_done", c, done_w[c], 0);
      end
    end

    run_frame(0, 18'h2A5C3, 1'b0, '0);
    run_frame(1, 18'h00FFF, 1'b0, '0);
    run_frame(2, 18'h000C3, 1'b0, '0);
    run_frame(3, 18'h000C3, 1'b0, '0);

    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        run_frame(c, rnd(c), 1'b0, '0);
      end
    end

    for (int c = 0; c < 4; c++) begin
      d1 = rnd(c);
      d2 = rnd(c);
      run_frame(c, d1, 1'b1, d2);
      run_frame(c, d2, 1'b0, '0);
    end

    // Abort dut0 during a data bit of its second character.
    valid_r[0] = 1'b1;
    data_r[0]  = rnd(0);
    @(posedge clk);
    #1;
    valid_r[0] = 1'b0;
    repeat (62) @(negedge clk);
    chk("pre_abort_busy", 0, busy_w[0], 1);
    rst_x = 1'b0;
    #1;
    chk("abort_sout", 0, sout_w[0], 1);
    chk("abort_ready", 0, ready_w[0], 1);
    chk("abort_busy", 0, busy_w[0], 0);
    chk("abort_done", 0, done_w[0], 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_hold_done", 0, done_w[0], 0);
      chk("abort_hold_sout", 0, sout_w[0], 1);
    end
    rst_x = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      chk("post_abort_done", 0, done_w[0], 0);
      chk("post_abort_sout", 0, sout_w[0], 1);
    end
    run_frame(0, rnd(0), 1'b0, '0);
    run_frame(1, rnd(1), 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frm.md
# uart_tx_frm

Parametrised UART framing transmitter for the monitor path. It accepts one DATA_W-bit payload word over a valid/ready handshake and splits it LSB-first into NCHAR characters of CHAR_W bits each. Each character goes out on uart_sout as start bit, data bits (LSB first), optional parity bit and NUM_STOP stop bits. The block has its own baud divider, optional inter-character idle gap and a completion pulse, so it needs no external bit timer.

## Interface
Parameters:
- DATA_W, 18: payload width, ≥1.
- CHAR_W, 8: data bits per character, 5..8.
- NUM_STOP, 2: stop bits per character, 1 or 2.
- PARITY, 0: parity mode.
  - 0: none.
  - 1: even.
  - 2: odd.
- GAP_BITS, 0: idle (mark) bit-times inserted between characters, 0..15. There is no gap after the last character.
- BAUD_DIV, 4: clk cycles per bit-time, ≥2.
- Derived: NCHAR = ceil(DATA_W/CHAR_W). The last character is zero-padded in its upper bits.

Ports:
- clk  in  1  clock.
- rst_x  in  1  reset, asynchronous, active-low.
- tx_valid  in  1  payload valid.
- tx_ready  out  1  block idle, payload accepted when tx_valid & tx_ready.
- tx_data  in  DATA_W  payload, sampled only on the accept cycle.
- tx_done  out  1  one-cycle pulse on the final cycle of the last stop bit.
- tx_busy  out  1  high from the cycle after accept until returning to IDLE.
- uart_sout  out  1  serial line, idle high (mark).

## Operation
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA → PARITY (skipped if PARITY=0) → STOP.
  - STOP after NUM_STOP bit-times goes to one of:
    - GAP, if more characters remain and GAP_BITS>0;
    - START, if more characters remain and GAP_BITS=0;
    - IDLE, after the last character.
  - GAP → START after GAP_BITS bit-times.
- Counters:
  - Baud counter 0..BAUD_DIV-1. It is cleared on accept and on every bit boundary. A bit ends when count = BAUD_DIV-1.
  - Bit index 0..CHAR_W-1 within DATA.
  - Stop/gap counter.
  - Character index 0..NCHAR-1.
- Accept latches tx_data into a NCHAR*CHAR_W shift register, zero-extended. A character is taken from the low CHAR_W bits. At STOP end the register shifts right by CHAR_W.
- Parity is computed over all CHAR_W bits of the current character, including pad zeros.
  - Even: the XOR of the data bits.
  - Odd: its inverse.
- uart_sout is registered (glitch-free) and takes these values:
  - 0 in START.
  - Data bit in DATA.
  - Parity in PARITY.
  - 1 in STOP, GAP and IDLE.
- tx_valid while busy is ignored, and the data is not latched. tx_data changing after accept has no effect.
- Reset asserted mid-frame:
  - State goes to IDLE immediately and all counters clear.
  - uart_sout goes to 1 and tx_done to 0.
  - No partial completion pulse is produced.

## Timing
- Reset values:
  - tx_ready=1, tx_busy=0, tx_done=0, uart_sout=1.
  - Shift register all zeros.
- Accept on cycle T: uart_sout falls at T+1. Each bit is held exactly BAUD_DIV cycles.
- Bits per character B = 1 + CHAR_W + (PARITY≠0) + NUM_STOP.
- Frame length L = (NCHAR·B + (NCHAR−1)·GAP_BITS)·BAUD_DIV cycles, spanning T+1..T+L.
- tx_done is high on cycle T+L only.
- On T+L+1: tx_ready=1 and tx_busy=0. Earliest next accept is T+L+1, which gives back-to-back transfers with zero extra idle bit-times.
- tx_ready and tx_busy are complementary at all times.
- A tx_valid held continuously is accepted once per frame.

## Test plan
- Reset/idle: hold rst_x=0 then release, with no tx_valid → uart_sout=1, tx_ready=1, tx_busy=0 and tx_done=0 for 100 cycles.
- Default frame: defaults, tx_data=18'h2A5C3 → three characters 0xC3, 0xA5, 0x02. Each is start 0, 8 LSB-first bits, then 2 stop bits of 1. Every bit is 4 cycles; L=132; tx_done only at T+132.
- Parity: CHAR_W=8, PARITY=1, DATA_W=8, data 8'hC3 → parity bit 0, L=(1+8+1+2)·4=48. With PARITY=2 → parity bit 1.
- Gap and odd width: DATA_W=12, CHAR_W=7, NUM_STOP=1, GAP_BITS=3, BAUD_DIV=5, data 12'hFFF:
  - Two characters 7'h7F and 7'h1F (pad zeros).
  - 15 cycles of mark between them.
  - L=(2·9+3)·5=105.
- Back-to-back: tx_valid held high with two words → second start bit begins at T+L+2 (second accept at T+L+1). No extra idle and no dropped or duplicated word.
- Reset mid-frame: assert rst_x during the DATA bit of the second character.
  - uart_sout=1 and tx_ready=1 immediately.
  - No tx_done.
  - The next transfer after release is bit-exact.
